// File: rtl/arb16_pkg.sv
// Shared constants, state encoding and round-robin pick function for the
// 16-way arbiter.
package arb16_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  // Scan last_idx+1, last_idx+2, ... (mod 16) and return the first requester
  // found. The offset of 16 wraps back to last_idx itself, so it is tried last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last_idx);
    logic [IDX_W-1:0] cand;
    logic             found;
    rr_pick = last_idx;
    found   = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = last_idx + off[IDX_W-1:0];
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/decoder_4to16.sv
// 4-to-16 one-hot decoder with enable; the output is all zero when disabled.
module decoder_4to16 (
  input  logic        enable,
  input  logic [3:0]  binary_in,
  output logic [15:0] decoder_out
);

  always_comb begin
    decoder_out = '0;
    if (enable) decoder_out[binary_in] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with hold-until-release grants,
// a MAX_HOLD forced rotation and a programmable dead gap between grants.
module rr_arbiter_16
  import arb16_pkg::*;
#(
  parameter int MAX_HOLD   = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  output logic        grant_valid,
  output logic [3:0]  grant_idx,
  output logic [15:0] grant_onehot,
  output logic        preempted
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam logic [1:0] GAP_LIM  = 2'(GAP_CYCLES);

  arb_state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] last_q, last_d;
  logic       valid_q, valid_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] gap_q, gap_d;
  logic       pre_q, pre_d;

  logic [3:0]  pickIdx;
  logic [15:0] otherReq;
  logic        take;

  assign pickIdx  = rr_pick(req, last_q);
  assign otherReq = req & ~(16'd1 << idx_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      last_q  <= 4'hF;
      valid_q <= 1'b0;
      hold_q  <= 8'd0;
      gap_q   <= 2'd0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      pre_q   <= pre_d;
    end
  end

  // The final GAP edge doubles as the first IDLE evaluation, so the
  // release-to-next-grant latency stays at GAP_CYCLES+1 edges.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    pre_d   = 1'b0;
    take    = 1'b0;
    unique case (state_q)
      ST_IDLE: take = |req;
      ST_GRANT: begin
        if (!req[idx_q] || (hold_q == HOLD_LIM && |otherReq)) begin
          pre_d   = req[idx_q];
          valid_d = 1'b0;
          last_d  = idx_q;
          hold_d  = 8'd0;
          gap_d   = 2'd0;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else if (hold_q != HOLD_LIM) begin
          hold_d = hold_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_q + 2'd1 == GAP_LIM) begin
          gap_d   = 2'd0;
          state_d = ST_IDLE;
          take    = |req;
        end else begin
          gap_d = gap_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      state_d = ST_GRANT;
      idx_d   = pickIdx;
      valid_d = 1'b1;
      hold_d  = 8'd1;
    end
  end

  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;
  assign preempted   = pre_q;

  decoder_4to16 u_dec (
    .enable      (valid_q),
    .binary_in   (idx_q),
    .decoder_out (grant_onehot)
  );

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Bench for rr_arbiter_16: two instances (GAP_CYCLES=1 and 0) checked every
// cycle against a behavioural model, plus directed scenario checks.
module tb_rr_arbiter_16;

  localparam int MAXH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;

  logic        gv0, gv1, pe0, pe1;
  logic [3:0]  gi0, gi1;
  logic [15:0] go0, go1;

  int checks = 0;
  int errors = 0;

  bit mBusy[2], mInGap[2], mPre[2];
  int mIdx[2], mHeld[2], mGapLeft[2], mLast[2];

  always #5 clk = ~clk;

  rr_arbiter_16 #(.MAX_HOLD(MAXH), .GAP_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant_valid(gv0),
    .grant_idx(gi0), .grant_onehot(go0), .preempted(pe0));

  rr_arbiter_16 #(.MAX_HOLD(MAXH), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant_valid(gv1),
    .grant_idx(gi1), .grant_onehot(go1), .preempted(pe1));

  function automatic int gapOf(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // First requester found scanning upward from the one after 'last', wrapping.
  function automatic int modelPick(input logic [15:0] r, input int last);
    for (int off = 1; off <= 16; off++)
      if (r[(last + off) % 16]) return (last + off) % 16;
    return -1;
  endfunction

  task automatic modelEdge(input int k, input logic [15:0] r, input logic rn);
    bit tryGrant;
    tryGrant = 0;
    if (!rn) begin
      mBusy[k] = 0; mInGap[k] = 0; mPre[k] = 0;
      mIdx[k] = 0; mHeld[k] = 0; mGapLeft[k] = 0; mLast[k] = 15;
      return;
    end
    mPre[k] = 0;
    if (mBusy[k]) begin
      if (!r[mIdx[k]] || (mHeld[k] >= MAXH && (r & ~(16'd1 << mIdx[k])) != 0)) begin
        mPre[k]  = r[mIdx[k]];
        mBusy[k] = 0;
        mLast[k] = mIdx[k];
        if (gapOf(k) > 0) begin
          mInGap[k]   = 1;
          mGapLeft[k] = gapOf(k);
        end
      end else if (mHeld[k] < MAXH) begin
        mHeld[k]++;
      end
    end else if (mInGap[k]) begin
      mGapLeft[k]--;
      if (mGapLeft[k] == 0) begin
        mInGap[k] = 0;
        tryGrant  = 1;
      end
    end else begin
      tryGrant = 1;
    end
    if (tryGrant && r != 0) begin
      mBusy[k] = 1;
      mIdx[k]  = modelPick(r, mLast[k]);
      mHeld[k] = 1;
    end
  endtask

  task automatic checkOutput(input int k);
    logic        v, p;
    logic [3:0]  i;
    logic [15:0] oh, expOh;
    v  = (k == 0) ? gv0 : gv1;
    p  = (k == 0) ? pe0 : pe1;
    i  = (k == 0) ? gi0 : gi1;
    oh = (k == 0) ? go0 : go1;
    expOh = mBusy[k] ? (16'd1 << mIdx[k]) : 16'd0;
    checkVal($sformatf("dut%0d.grant_valid", k), {15'd0, v}, {15'd0, mBusy[k]});
    checkVal($sformatf("dut%0d.grant_idx", k), {12'd0, i}, 16'(mIdx[k]));
    checkVal($sformatf("dut%0d.grant_onehot", k), oh, expOh);
    checkVal($sformatf("dut%0d.preempted", k), {15'd0, p}, {15'd0, mPre[k]});
  endtask

  task automatic applyStimulus(input logic [15:0] r, input logic rn);
    req   = r;
    rst_n = rn;
    @(posedge clk);
    modelEdge(0, r, rn);
    modelEdge(1, r, rn);
    #1;
    checkOutput(0);
    checkOutput(1);
  endtask

  initial begin
    int          order[$];
    int          expOrder[5];
    int          gapRun, len3, pulses, nextIdx, bad;
    logic        prevV;
    logic [15:0] cur;
    logic [31:0] rnd;

    expOrder = '{0, 5, 10, 15, 0};
    req   = 16'h0;
    rst_n = 1'b0;
    #2;

    // Reset with everyone requesting, then the first grant goes to 0.
    repeat (3) applyStimulus(16'hFFFF, 1'b0);
    checkVal("reset valid", {15'd0, gv0}, 16'd0);
    checkVal("reset onehot", go0, 16'd0);
    applyStimulus(16'hFFFF, 1'b1);
    checkVal("first grant idx", {12'd0, gi0}, 16'd0);
    checkVal("first grant onehot", go0, 16'h0001);

    // Rotation among 0,5,10,15: each holder drops after two granted cycles.
    applyStimulus(16'h0, 1'b0);
    prevV  = 1'b0;
    gapRun = 0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      cur = 16'h8421;
      if (mBusy[0] && mHeld[0] >= 2) cur &= ~(16'd1 << mIdx[0]);
      applyStimulus(cur, 1'b1);
      if (gv0 && !prevV) begin
        if (order.size() > 0) checkVal("rotation gap length", 16'(gapRun), 16'd1);
        order.push_back(int'(gi0));
      end
      if (!gv0) gapRun++;
      else gapRun = 0;
      prevV = gv0;
    end
    checkVal("rotation grant count", 16'(order.size()), 16'd5);
    for (int n = 0; n < order.size() && n < 5; n++)
      checkVal($sformatf("rotation order[%0d]", n), 16'(order[n]), 16'(expOrder[n]));

    // Preemption: 3 holds, 7 joins later; 3 must be cut after MAX_HOLD cycles.
    applyStimulus(16'h0, 1'b0);
    len3 = 0; pulses = 0; nextIdx = -1;
    for (int c = 0; c < 14; c++) begin
      applyStimulus((c < 3) ? 16'h0008 : 16'h0088, 1'b1);
      if (gv0 && gi0 == 4'd3) len3++;
      if (pe0) pulses++;
      if (gv0 && gi0 != 4'd3 && nextIdx < 0) nextIdx = int'(gi0);
    end
    checkVal("preempt hold length", 16'(len3), 16'(MAXH));
    checkVal("preempt pulse count", 16'(pulses), 16'd1);
    checkVal("preempt next idx", 16'(nextIdx), 16'd7);

    // A lone requester keeps the grant indefinitely.
    applyStimulus(16'h0, 1'b0);
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      applyStimulus(16'h1000, 1'b1);
      if (!(gv0 && gi0 == 4'd12) || pe0 || !(gv1 && gi1 == 4'd12) || pe1) bad++;
    end
    checkVal("lone holder violations", 16'(bad), 16'd0);

    // Wrap-around with no gap: after 14 releases, 0 wins over 1 and 14.
    applyStimulus(16'h0, 1'b0);
    applyStimulus(16'h4000, 1'b1);
    checkVal("wrap first idx", {12'd0, gi1}, 16'd14);
    applyStimulus(16'h0003, 1'b1);
    checkVal("wrap release valid", {15'd0, gv1}, 16'd0);
    applyStimulus(16'h4003, 1'b1);
    checkVal("wrap next valid", {15'd0, gv1}, 16'd1);
    checkVal("wrap next idx", {12'd0, gi1}, 16'd0);
    checkVal("wrap next onehot", go1, 16'h0001);

    // Reset in the middle of a grant restores requester 0 priority.
    applyStimulus(16'h0, 1'b0);
    applyStimulus(16'h0200, 1'b1);
    checkVal("midreset grant idx", {12'd0, gi0}, 16'd9);
    applyStimulus(16'h0200, 1'b0);
    checkVal("midreset valid", {15'd0, gv0}, 16'd0);
    checkVal("midreset onehot", go0, 16'd0);
    applyStimulus(16'h0201, 1'b1);
    checkVal("post reset idx", {12'd0, gi0}, 16'd0);
    checkVal("post reset onehot", go0, 16'h0001);

    // Sticky random requests with sparse bit flips and occasional resets.
    cur = 16'h0;
    for (int c = 0; c < 600; c++) begin
      rnd = $urandom & $urandom & $urandom;
      cur ^= rnd[15:0];
      applyStimulus(cur, ($urandom_range(0, 59) != 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
